// File: rtl/id_ex_stage.sv
// ID/EX pipeline register sitting in front of the ALU.
// Captures decoded operands with EX/MEM/WB bypassing resolved at capture time.
// It also selects the immediate for operand b, and handles load-use bubbles,
// downstream stall and branch flush.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_rs_val,
    input  logic [DW-1:0] id_rt_val,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic [3:0]    id_alu_func,
    input  logic [4:0]    id_shamt,
    input  logic          id_alu_src_imm,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_reg_write,
    input  logic          ex_stall,
    input  logic          flush,
    input  logic [DW-1:0] ex_alu_y,
    input  logic          mem_fwd_en,
    input  logic [RW-1:0] mem_fwd_rd,
    input  logic [DW-1:0] mem_fwd_data,
    input  logic          wb_fwd_en,
    input  logic [RW-1:0] wb_fwd_rd,
    input  logic [DW-1:0] wb_fwd_data,
    output logic          ex_valid,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [3:0]    ex_func,
    output logic [4:0]    ex_shamt,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_rd,
    output logic [DW-1:0] ex_pc,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_reg_write
);

    logic          r_valid;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [3:0]    r_func;
    logic [4:0]    r_shamt;
    logic [DW-1:0] r_store_data;
    logic [RW-1:0] r_rd;
    logic [DW-1:0] r_pc;
    logic          r_mem_read;
    logic          r_mem_write;
    logic          r_reg_write;

    logic          w_ex_fwd_en;
    logic          w_load_use;
    logic          w_capture;
    logic [DW-1:0] w_fwd_rs;
    logic [DW-1:0] w_fwd_rt;

    // Bypass mux for one source operand: youngest producer wins, r0 never forwards.
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] idx,
        input logic [DW-1:0] rf_val,
        input logic          ex_en,
        input logic [RW-1:0] ex_idx,
        input logic [DW-1:0] ex_data,
        input logic          mem_en,
        input logic [RW-1:0] mem_idx,
        input logic [DW-1:0] mem_data,
        input logic          wb_en,
        input logic [RW-1:0] wb_idx,
        input logic [DW-1:0] wb_data
    );
        logic [DW-1:0] v;
        v = rf_val;
        if (idx != '0) begin
            if (ex_en && ex_idx == idx)
                v = ex_data;
            else if (mem_en && mem_idx == idx)
                v = mem_data;
            else if (wb_en && wb_idx == idx)
                v = wb_data;
        end
        return v;
    endfunction

    // A load in EX has no data yet, so EX bypass is only legal for non-load writers.
    assign w_ex_fwd_en = r_valid & r_reg_write & ~r_mem_read;

    assign w_load_use = r_valid & r_mem_read & (r_rd != '0) & id_valid &
                        ((id_uses_rs & (id_rs == r_rd)) | (id_uses_rt & (id_rt == r_rd)));

    // A flush consumes (and discards) the decode instruction even while stalled.
    assign id_ready  = flush | (~ex_stall & ~w_load_use);
    assign w_capture = ~flush & ~ex_stall & ~w_load_use & id_valid;

    // Resolve both source operands against the in-flight producers.
    always_comb begin
        w_fwd_rs = fwd_sel(id_rs, id_rs_val, w_ex_fwd_en, r_rd, ex_alu_y,
                           mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                           wb_fwd_en, wb_fwd_rd, wb_fwd_data);
        w_fwd_rt = fwd_sel(id_rt, id_rt_val, w_ex_fwd_en, r_rd, ex_alu_y,
                           mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                           wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    end

    // Stage register: flush > stall > load-use bubble > capture > idle bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_func       <= '0;
            r_shamt      <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_pc         <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (!ex_stall) begin
            if (w_capture) begin
                r_valid      <= 1'b1;
                r_a          <= w_fwd_rs;
                r_b          <= id_alu_src_imm ? id_imm : w_fwd_rt;
                r_func       <= id_alu_func;
                r_shamt      <= id_shamt;
                r_store_data <= w_fwd_rt;
                r_rd         <= id_rd;
                r_pc         <= id_pc;
                r_mem_read   <= id_mem_read;
                r_mem_write  <= id_mem_write;
                r_reg_write  <= id_reg_write;
            end else begin
                r_valid     <= 1'b0;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_reg_write <= 1'b0;
            end
        end
    end

    assign ex_valid      = r_valid;
    assign ex_a          = r_a;
    assign ex_b          = r_b;
    assign ex_func       = r_func;
    assign ex_shamt      = r_shamt;
    assign ex_store_data = r_store_data;
    assign ex_rd         = r_rd;
    assign ex_pc         = r_pc;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_reg_write  = r_reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios plus random traffic,
// all checked against a transaction-level model of the EX register.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_ready;
    logic [DW-1:0] id_pc, id_rs_val, id_rt_val, id_imm;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic          id_uses_rs, id_uses_rt;
    logic [3:0]    id_alu_func;
    logic [4:0]    id_shamt;
    logic          id_alu_src_imm, id_mem_read, id_mem_write, id_reg_write;
    logic          ex_stall, flush;
    logic [DW-1:0] ex_alu_y;
    logic          mem_fwd_en, wb_fwd_en;
    logic [RW-1:0] mem_fwd_rd, wb_fwd_rd;
    logic [DW-1:0] mem_fwd_data, wb_fwd_data;
    logic          ex_valid;
    logic [DW-1:0] ex_a, ex_b, ex_store_data, ex_pc;
    logic [3:0]    ex_func;
    logic [4:0]    ex_shamt;
    logic [RW-1:0] ex_rd;
    logic          ex_mem_read, ex_mem_write, ex_reg_write;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_alu_func(id_alu_func), .id_shamt(id_shamt),
        .id_alu_src_imm(id_alu_src_imm), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .ex_stall(ex_stall), .flush(flush), .ex_alu_y(ex_alu_y),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_func(ex_func),
        .ex_shamt(ex_shamt), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_pc(ex_pc), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write)
    );

    // Model of what EX should be holding.
    typedef struct packed {
        logic          v;
        logic [DW-1:0] a, b, sd, pc;
        logic [3:0]    func;
        logic [4:0]    shamt;
        logic [RW-1:0] rd;
        logic          mr, mw, rw;
    } ex_t;
    ex_t m;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Value the architecture says a source register holds right now.
    function automatic logic [DW-1:0] ref_val(input logic [RW-1:0] idx, input logic [DW-1:0] rf);
        if (idx == 0) return rf;
        if (m.v && m.rw && !m.mr && m.rd == idx) return ex_alu_y;
        if (mem_fwd_en && mem_fwd_rd == idx) return mem_fwd_data;
        if (wb_fwd_en && wb_fwd_rd == idx) return wb_fwd_data;
        return rf;
    endfunction

    function automatic logic ref_hazard();
        if (!(m.v && m.mr && m.rd != 0 && id_valid)) return 1'b0;
        return (id_uses_rs && id_rs == m.rd) || (id_uses_rt && id_rt == m.rd);
    endfunction

    task automatic check_outputs(input ex_t e);
        check("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
        check("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, e.mr});
        check("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, e.mw});
        check("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
        check("ex_a", ex_a, e.a);
        check("ex_b", ex_b, e.b);
        check("ex_store_data", ex_store_data, e.sd);
        check("ex_pc", ex_pc, e.pc);
        check("ex_func", {28'd0, ex_func}, {28'd0, e.func});
        check("ex_shamt", {27'd0, ex_shamt}, {27'd0, e.shamt});
        check("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
    endtask

    // One clock: called at a negedge with inputs already applied, returns at the next negedge.
    task automatic cycle();
        ex_t nxt;
        logic hz, rdy;
        #1;
        hz  = ref_hazard();
        rdy = flush || (!ex_stall && !hz);
        check("id_ready", {31'd0, id_ready}, {31'd0, rdy});
        nxt = m;
        if (flush) begin
            nxt.v = 0; nxt.mr = 0; nxt.mw = 0; nxt.rw = 0;
        end else if (ex_stall) begin
            nxt = m;
        end else if (!hz && id_valid) begin
            nxt.v     = 1;
            nxt.a     = ref_val(id_rs, id_rs_val);
            nxt.sd    = ref_val(id_rt, id_rt_val);
            nxt.b     = id_alu_src_imm ? id_imm : nxt.sd;
            nxt.pc    = id_pc;
            nxt.func  = id_alu_func;
            nxt.shamt = id_shamt;
            nxt.rd    = id_rd;
            nxt.mr    = id_mem_read;
            nxt.mw    = id_mem_write;
            nxt.rw    = id_reg_write;
        end else begin
            nxt.v = 0; nxt.mr = 0; nxt.mw = 0; nxt.rw = 0;
        end
        @(posedge clk);
        #1;
        m = nxt;
        check_outputs(m);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_pc = 0; id_rs_val = 0; id_rt_val = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_alu_func = 0; id_shamt = 0; id_alu_src_imm = 0;
        id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
        ex_stall = 0; flush = 0; ex_alu_y = 0;
        mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
    endtask

    task automatic instr(input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                         input logic [DW-1:0] rsv, input logic [DW-1:0] rtv,
                         input logic mr, input logic rw);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_val = rsv; id_rt_val = rtv; id_uses_rs = 1; id_uses_rt = 1;
        id_alu_func = 4'b0000; id_alu_src_imm = 0; id_mem_read = mr;
        id_mem_write = 0; id_reg_write = rw; id_pc = id_pc + 4;
    endtask

    initial begin
        idle_inputs();
        m   = '0;
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        check_outputs(m);
        rst = 0;

        // Basic capture: ADD r3 = r1 + r2 with rf values 5, 7.
        instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 0, 1);
        cycle();
        check("basic_a", ex_a, 32'd5);
        check("basic_b", ex_b, 32'd7);

        // Back-to-back dependency on r3 takes the live ALU result.
        instr(5'd3, 5'd2, 5'd6, 32'h99, 32'd7, 0, 1);
        ex_alu_y = 32'h10;
        cycle();
        check("ex_fwd_a", ex_a, 32'h10);

        // Writer to r0 must not forward.
        instr(5'd1, 5'd2, 5'd0, 32'd1, 32'd2, 0, 1);
        cycle();
        instr(5'd0, 5'd2, 5'd7, 32'h55, 32'd2, 0, 1);
        ex_alu_y = 32'h10;
        cycle();
        check("r0_no_fwd", ex_a, 32'h55);

        // Load r4, then a consumer of rt=r4: one bubble, then MEM bypass.
        instr(5'd1, 5'd2, 5'd4, 32'd0, 32'd0, 1, 1);
        cycle();
        instr(5'd1, 5'd4, 5'd8, 32'd3, 32'd1, 0, 1);
        cycle();
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        mem_fwd_en = 1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'hAB;
        cycle();
        check("lu_mem_fwd_b", ex_b, 32'hAB);
        mem_fwd_en = 0;

        // Downstream stall for three cycles, then release.
        instr(5'd9, 5'd10, 5'd11, 32'h111, 32'h222, 0, 1);
        ex_stall = 1;
        repeat (3) cycle();
        ex_stall = 0;
        cycle();
        check("post_stall_a", ex_a, 32'h111);

        // Flush beats stall.
        instr(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 0, 1);
        id_mem_write = 1;
        ex_stall = 1; flush = 1;
        cycle();
        ex_stall = 0; flush = 0;

        // Async reset while a load-use hazard is pending.
        instr(5'd1, 5'd2, 5'd5, 32'd0, 32'd0, 1, 1);
        cycle();
        instr(5'd5, 5'd2, 5'd6, 32'd1, 32'd2, 0, 1);
        #1;
        check("lu_ready_low", {31'd0, id_ready}, 32'd0);
        #1 rst = 1;
        #1;
        m = '0;
        check_outputs(m);
        @(negedge clk);
        rst = 0;
        instr(5'd1, 5'd2, 5'd3, 32'h77, 32'h88, 0, 1);
        cycle();
        check("post_rst_a", ex_a, 32'h77);

        // Random traffic over a small register range so hazards and bypasses occur often.
        for (int i = 0; i < 400; i++) begin
            id_valid       = ($urandom_range(9) < 8);
            id_pc          = $urandom;
            id_rs_val      = $urandom;
            id_rt_val      = $urandom;
            id_imm         = $urandom;
            id_rs          = RW'($urandom_range(7));
            id_rt          = RW'($urandom_range(7));
            id_rd          = RW'($urandom_range(7));
            id_uses_rs     = $urandom_range(1);
            id_uses_rt     = $urandom_range(1);
            id_alu_func    = 4'($urandom_range(8));
            id_shamt       = 5'($urandom);
            id_alu_src_imm = $urandom_range(1);
            id_mem_read    = ($urandom_range(3) == 0);
            id_mem_write   = ($urandom_range(3) == 0);
            id_reg_write   = $urandom_range(1);
            ex_stall       = ($urandom_range(4) == 0);
            flush          = ($urandom_range(9) == 0);
            ex_alu_y       = $urandom;
            mem_fwd_en     = $urandom_range(1);
            mem_fwd_rd     = RW'($urandom_range(7));
            mem_fwd_data   = $urandom;
            wb_fwd_en      = $urandom_range(1);
            wb_fwd_rd      = RW'($urandom_range(7));
            wb_fwd_data    = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
